// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared state encodings, width defaults and flag bit positions for mem_loader
package mem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // Loader state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_COLLECT = 3'd1;
    localparam state_t ST_WRITE   = 3'd2;
    localparam state_t ST_CHECK   = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    // Bit positions inside flg
    localparam int FLG_DONE     = 3;
    localparam int FLG_CNT_ERR  = 2;
    localparam int FLG_CSUM_ERR = 1;
    localparam int FLG_BUSY     = 0;

endpackage

// File: rtl/mem_loader_pack.sv
// rtl/mem_loader_pack.sv - big-endian byte-to-word assembler (shift register plus 2-bit byte index)
module mem_loader_pack #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              last
);

    logic [1:0] idx;

    // The byte being shifted in now completes the word
    assign last = shift_en && (idx == 2'd3);

    // Shift bytes in from the bottom so the first byte ends up in the top lane
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            idx  <= 2'd0;
        end else if (clear) begin
            word <= '0;
            idx  <= 2'd0;
        end else if (shift_en) begin
            word <= {word[DATA_W-9:0], byte_in};
            idx  <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream to word-memory loader; optional trailer checksum under CHECKSUM_EN
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic [3:0]        flg
);

`ifdef CHECKSUM_EN
    localparam state_t ST_AFTER_LAST = ST_CHECK;
`else
    localparam state_t ST_AFTER_LAST = ST_DONE;
`endif

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rem_cnt;
    logic              cnt_err;
    logic              csum_err;
    logic              byte_acc;
    logic              start_ok;
    logic              word_full;
    logic [DATA_W-1:0] word;

    assign in_ready  = (state == ST_COLLECT) || (state == ST_CHECK);
    assign byte_acc  = in_valid && in_ready;
    assign start_ok  = (state == ST_IDLE) && start && (word_count != '0);
    assign mem_we    = (state == ST_WRITE);
    assign mem_addr  = addr;
    assign mem_wdata = word;
    assign busy      = (state != ST_IDLE);

    mem_loader_pack #(
        .DATA_W(DATA_W)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .shift_en(byte_acc && (state == ST_COLLECT)),
        .byte_in (in_data),
        .word    (word),
        .last    (word_full)
    );

    // Load sequencing: capture request, collect four bytes, write, advance address/count
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr    <= '0;
            rem_cnt <= '0;
            cnt_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        addr    <= base_addr;
                        rem_cnt <= word_count;
                        cnt_err <= 1'b0;
                        state   <= ST_COLLECT;
                    end else if (start) begin
                        cnt_err <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_COLLECT: begin
                    if (word_full) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr    <= addr + ADDR_W'(1);
                    rem_cnt <= rem_cnt - (ADDR_W+1)'(1);
                    state   <= (rem_cnt == (ADDR_W+1)'(1)) ? ST_AFTER_LAST : ST_COLLECT;
                end
                ST_CHECK: begin
                    if (byte_acc) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of payload bytes; the trailer byte is compared against it in CHECK
    always_ff @(posedge clk) begin
        if (rst) begin
            csum     <= 8'h00;
            csum_err <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            csum     <= 8'h00;
            csum_err <= 1'b0;
        end else if (byte_acc && (state == ST_COLLECT)) begin
            csum <= csum ^ in_data;
        end else if (byte_acc && (state == ST_CHECK)) begin
            csum_err <= (in_data != csum);
        end
    end
`else
    assign csum_err = 1'b0;
`endif

    // Status flags; flg[0] marks an active transfer, so the DONE cycle reads back as done-only
    always_comb begin
        flg               = 4'b0000;
        flg[FLG_DONE]     = (state == ST_DONE);
        flg[FLG_CNT_ERR]  = cnt_err;
        flg[FLG_CSUM_ERR] = csum_err;
        flg[FLG_BUSY]     = (state == ST_COLLECT) || (state == ST_WRITE) || (state == ST_CHECK);
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - scoreboard testbench for mem_loader (optionally built with CHECKSUM_EN)
module tb_mem_loader;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic [3:0]    flg;

    mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .flg       (flg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [3:0] dq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_seen = 0;
    int         done_cyc = 0;
    int         last_we_cyc = -1;
    int         exp_gap = 0;
    logic [7:0]  bv[0:7];
    logic [31:0] wv[0:1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops expected writes and done flags whenever the DUT presents them
    always @(negedge clk) begin : monitor
        wr_t        e;
        logic [3:0] f;
        if (!rst) begin
            if (mem_we) begin
                chk("write_expected", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
                chk("in_ready_write", in_ready, 0);
                if (exp_gap != 0 && last_we_cyc >= 0)
                    chk("write_spacing", cyc - last_we_cyc, exp_gap);
                last_we_cyc = cyc;
            end
            if (flg[3]) begin
                chk("done_expected", dq.size() > 0, 1);
                if (dq.size() > 0) begin
                    f = dq.pop_front();
                    chk("done_flg", flg, f);
                end
                chk("in_ready_done", in_ready, 0);
                chk("busy_done", busy, 1);
                done_cyc = cyc;
                done_seen++;
            end
        end
    end

    task automatic issue_start(input logic [7:0] base, input int count);
        start      = 1'b1;
        base_addr  = base;
        word_count = count[AW:0];
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_seen", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_done(input int base_seen, input int limit);
        int n = 0;
        while (done_seen == base_seen && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_seen != base_seen, 1);
    endtask

    task automatic run_load(input logic [7:0] base, input int count, input bit gappy,
                            input logic [7:0] tdelta);
        logic [7:0] x = 8'h00;
        logic [7:0] a = base;
        int         s;
        for (int w = 0; w < count; w++) begin
            wq.push_back('{a, wv[w]});
            a = a + 8'd1;
        end
        dq.push_back({1'b1, 1'b0, CS && (tdelta != 8'h00), 1'b0});
        s = done_seen;
        issue_start(base, count);
        chk("busy_load", busy, 1);
        chk("flg_load", flg, 4'b0001);
        for (int i = 0; i < count * 4; i++) begin
            if (gappy) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(bv[i]);
            x = x ^ bv[i];
        end
`ifdef CHECKSUM_EN
        send_byte(x ^ tdelta);
`endif
        in_valid = 1'b0;
        wait_done(s, 100);
        @(negedge clk);
    endtask

    initial begin
        int s;
        int s_cyc;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_data = 8'h00; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flg", flg, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        // Two words at full rate from address 0
        bv[0] = 8'h01; bv[1] = 8'h02; bv[2] = 8'h03; bv[3] = 8'h04;
        bv[4] = 8'hAA; bv[5] = 8'hBB; bv[6] = 8'hCC; bv[7] = 8'hDD;
        wv[0] = 32'h01020304; wv[1] = 32'hAABBCCDD;
        exp_gap = 5; last_we_cyc = -1;
        run_load(8'h00, 2, 1'b0, 8'h00);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_flg", flg, 4'b0000);

        // Address wrap from 255 to 0
        bv[0] = 8'h11; bv[1] = 8'h22; bv[2] = 8'h33; bv[3] = 8'h44;
        bv[4] = 8'h55; bv[5] = 8'h66; bv[6] = 8'h77; bv[7] = 8'h88;
        wv[0] = 32'h11223344; wv[1] = 32'h55667788;
        last_we_cyc = -1;
        run_load(8'hFF, 2, 1'b0, 8'h00);

        // Zero word count
        exp_gap = 0;
        dq.push_back(4'b1100);
        s = done_seen;
        s_cyc = cyc;
        issue_start(8'h30, 0);
        wait_done(s, 10);
        chk("zero_cnt_latency", (done_cyc - s_cyc) <= 2, 1);
        repeat (2) @(negedge clk);
        chk("zero_cnt_hold_flg", flg, 4'b0100);

        // Throttled input stream
        bv[0] = 8'hDE; bv[1] = 8'hAD; bv[2] = 8'hBE; bv[3] = 8'hEF;
        wv[0] = 32'hDEADBEEF;
        run_load(8'h10, 1, 1'b1, 8'h00);
        chk("idle_in_ready2", in_ready, 0);

        // Reset in the middle of a word
        issue_start(8'h20, 1);
        send_byte(8'h12);
        send_byte(8'h34);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_flg", flg, 4'b0000);
        repeat (3) @(negedge clk);
        bv[0] = 8'hCA; bv[1] = 8'hFE; bv[2] = 8'hF0; bv[3] = 8'h0D;
        wv[0] = 32'hCAFEF00D;
        run_load(8'h21, 1, 1'b0, 8'h00);

`ifdef CHECKSUM_EN
        // Trailer checksum: 01^02^03^04 = 04
        bv[0] = 8'h01; bv[1] = 8'h02; bv[2] = 8'h03; bv[3] = 8'h04;
        wv[0] = 32'h01020304;
        run_load(8'h40, 1, 1'b0, 8'h00);
        chk("csum_ok_flg", flg, 4'b0000);
        run_load(8'h40, 1, 1'b0, 8'h01);
        chk("csum_bad_flg", flg, 4'b0010);
`endif

        repeat (3) @(negedge clk);
        chk("writes_drained", wq.size(), 0);
        chk("dones_drained", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 32, memory word width; always 4 bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle load request; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-007 SHALL have port word_count  input  ADDR_W+1  words to load (0..256), captured on accepted start.
REQ-008 SHALL have port in_data  input  8  byte stream payload.
REQ-009 SHALL have port in_valid  input  1  in_data valid; byte accepted when in_valid && in_ready.
REQ-010 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-011 SHALL have port mem_we  output  1  one-cycle memory write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-013 SHALL have port mem_wdata  output  DATA_W  write data.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port flg  output  4  {done, cnt_err, csum_err, busy}, bits [3:0].

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-017 IDLE: start=1 with word_count>0 SHALL capture base_addr/word_count, clear the byte index and flag bits [2:1], and go to COLLECT next cycle.
REQ-018 IDLE: start=1 with word_count=0 SHALL set flg[2], perform no write, and go to DONE.
REQ-019 COLLECT: in_ready SHALL be 1; the first accepted byte SHALL be bits [31:24], the fourth bits [7:0] (big-endian).
REQ-020 The fourth accepted byte SHALL move to WRITE; in WRITE, mem_we=1 for exactly one cycle with the assembled word and the current address.
REQ-021 After WRITE, the address SHALL increment modulo 2^ADDR_W (255 wraps to 0) and the remaining count SHALL decrement.
REQ-022 After WRITE, a nonzero remaining count SHALL return to COLLECT; zero SHALL go to CHECK when CHECKSUM_EN is defined, else to DONE.
REQ-023 in_ready SHALL be 0 in IDLE, WRITE, and DONE; in_valid stalls SHALL hold all state without penalty.
REQ-024 Maximum throughput SHALL be one word per 5 cycles.
REQ-025 DONE SHALL last one cycle with flg[3]=1, then return to IDLE; flg[2:1] SHALL hold until the next accepted start.
REQ-026 start while busy SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, flg=0 on the next edge.
REQ-028 rst mid-load SHALL discard any partial word, issue no write, and leave already-written words untouched.

Configuration
REQ-029 With CHECKSUM_EN defined, the loader SHALL keep a running XOR of all accepted data bytes.
REQ-030 With CHECKSUM_EN defined, CHECK SHALL assert in_ready and accept one trailer byte; a trailer not equal to the XOR SHALL set flg[1]; then go to DONE.
REQ-031 Without CHECKSUM_EN, CHECK SHALL be unreachable and flg[1] SHALL be constant 0.

Structure
REQ-032 A shared package SHALL hold the state enum, the ADDR_W/DATA_W defaults, and flag bit-index constants.
REQ-033 The byte-to-word assembler (shift register and 2-bit index) SHALL be one sub-module, mem_loader_pack.

Verification
REQ-034 base=0, count=2, bytes 01 02 03 04 AA BB CC DD at full rate: writes 0x01020304@0 and 0xAABBCCDD@1, mem_we 5 cycles apart, done pulse, flg=1000 in DONE.
REQ-035 base=255, count=2: writes at addresses 255 then 0.
REQ-036 count=0: no mem_we, flg[2]=1, DONE within 2 cycles of start.
REQ-037 in_valid toggled every other cycle, count=1, data 0xDEADBEEF: single correct write; in_ready low outside COLLECT/CHECK.
REQ-038 rst after 2 bytes of word 1: no write, state IDLE, flg=0; a fresh load then succeeds.
REQ-039 CHECKSUM_EN, data 01 02 03 04: trailer 04 gives flg[1]=0; trailer 05 gives flg[1]=1.
